// File: rtl/pool_engine_nch.sv
// N_CH-lane non-overlapping max/min/avg pooling engine over a run-time KH x KV window.
// Vertical partial results live in a row buffer indexed by output column.
module pool_engine_nch #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned K_MAX   = 4,
  parameter int unsigned ROW_MAX = 256,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned ACC_W   = DATA_W + 2 * $clog2(K_MAX)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [1:0]                 pool_type_i,
  input  logic [$clog2(K_MAX):0]     pool_horiz_i,
  input  logic [$clog2(K_MAX):0]     pool_vert_i,
  input  logic [4:0]                 avg_shift_i,
  input  logic [ADDR_W-1:0]          row_length_i,
  input  logic [ADDR_W-1:0]          num_rows_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [N_CH*DATA_W-1:0]     in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [N_CH*DATA_W-1:0]     out_data_o,
  output logic                       out_last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned KW     = $clog2(K_MAX) + 1;
  localparam int unsigned CW     = ADDR_W + 1;
  localparam int unsigned BUF_AW = $clog2(ROW_MAX);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StFin   = 2'd3;

  localparam logic signed [ACC_W-1:0] SatMax =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [1:0]        type_q;
  logic [KW-1:0]     kh_q, kv_q;
  logic [4:0]        shift_q;
  logic [ADDR_W-1:0] row_len_q, num_rows_q;
  logic [ADDR_W-1:0] cc_q, cc_d, rc_q, rc_d;
  logic [KW-1:0]     hc_q, hc_d, vc_q, vc_d;
  logic [BUF_AW-1:0] oc_q, oc_d;

  logic signed [ACC_W-1:0] h_acc_q [N_CH];
  logic [N_CH*ACC_W-1:0]   rbuf_q [ROW_MAX];

  logic                   out_valid_q, out_last_q;
  logic [N_CH*DATA_W-1:0] out_data_q;

  logic                   accept, col_ok, row_ok, h_end, v_end, row_end;
  logic                   last_col, last_row, win, emit;
  logic [N_CH*ACC_W-1:0]  h_new, wbuf;
  logic [N_CH*DATA_W-1:0] fin_data;

  function automatic logic signed [ACC_W-1:0] combine(input logic [1:0] t,
                                                      input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    case (t)
      2'd1:    return a + b;
      2'd2:    return (a < b) ? a : b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] finalize(input logic [1:0] t, input logic [4:0] sh,
                                                 input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v;
    if (t == 2'd1) begin
      s = v >>> sh;
      if (s > SatMax) s = SatMax;
      else if (s < SatMin) s = SatMin;
    end
    return s[DATA_W-1:0];
  endfunction

  assign in_ready_o = (state_q == StRun) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // A window is "full" when its start column/row plus the window size fits in the frame;
  // counters stop advancing in the trailing region, so start = cc-hc / rc-vc stays exact.
  assign col_ok   = (CW'(cc_q) - CW'(hc_q) + CW'(kh_q)) <= CW'(row_len_q);
  assign row_ok   = (CW'(rc_q) - CW'(vc_q) + CW'(kv_q)) <= CW'(num_rows_q);
  assign h_end    = hc_q == kh_q - KW'(1);
  assign v_end    = vc_q == kv_q - KW'(1);
  assign row_end  = cc_q == row_len_q - ADDR_W'(1);
  assign last_col = (CW'(cc_q) + CW'(1) + CW'(kh_q)) > CW'(row_len_q);
  assign last_row = (CW'(rc_q) + CW'(1) + CW'(kv_q)) > CW'(num_rows_q);
  assign win      = accept && col_ok && row_ok && h_end;
  assign emit     = win && v_end;

  always_comb begin
    logic signed [DATA_W-1:0] p;
    logic signed [ACC_W-1:0]  pix, h_val, b_val, v_val;
    h_new    = '0;
    wbuf     = '0;
    fin_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      p     = in_data_i[i*DATA_W +: DATA_W];
      pix   = ACC_W'(p);
      h_val = (hc_q == '0) ? pix : combine(type_q, h_acc_q[i], pix);
      b_val = rbuf_q[oc_q][i*ACC_W +: ACC_W];
      v_val = (vc_q == '0) ? h_val : combine(type_q, b_val, h_val);
      h_new[i*ACC_W +: ACC_W]        = h_val;
      wbuf[i*ACC_W +: ACC_W]         = v_val;
      fin_data[i*DATA_W +: DATA_W]   = finalize(type_q, shift_q, v_val);
    end
  end

  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    rc_d    = rc_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    oc_d    = oc_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          cc_d    = '0;
          rc_d    = '0;
          hc_d    = '0;
          vc_d    = '0;
          oc_d    = '0;
          state_d = (row_length_i == '0 || num_rows_i == '0) ? StFin : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          if (col_ok) begin
            hc_d = h_end ? '0 : hc_q + KW'(1);
            if (h_end) oc_d = oc_q + BUF_AW'(1);
          end
          if (row_end) begin
            cc_d = '0;
            hc_d = '0;
            oc_d = '0;
            rc_d = rc_q + ADDR_W'(1);
            if (row_ok) vc_d = v_end ? '0 : vc_q + KW'(1);
            if (rc_q == num_rows_q - ADDR_W'(1)) state_d = StDrain;
          end else begin
            cc_d = cc_q + ADDR_W'(1);
          end
        end
      end
      StDrain: if (!out_valid_q || out_ready_i) state_d = StFin;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      type_q     <= '0;
      kh_q       <= KW'(1);
      kv_q       <= KW'(1);
      shift_q    <= '0;
      row_len_q  <= '0;
      num_rows_q <= '0;
      cc_q       <= '0;
      rc_q       <= '0;
      hc_q       <= '0;
      vc_q       <= '0;
      oc_q       <= '0;
      for (int i = 0; i < N_CH; i++) h_acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      rc_q    <= rc_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      oc_q    <= oc_d;
      if (state_q == StIdle && start_i) begin
        type_q     <= pool_type_i;
        kh_q       <= (pool_horiz_i == '0) ? KW'(1) : pool_horiz_i;
        kv_q       <= (pool_vert_i == '0) ? KW'(1) : pool_vert_i;
        shift_q    <= avg_shift_i;
        row_len_q  <= row_length_i;
        num_rows_q <= num_rows_i;
      end
      if (accept && col_ok) begin
        for (int i = 0; i < N_CH; i++) h_acc_q[i] <= h_new[i*ACC_W +: ACC_W];
      end
    end
  end

  // Row buffer contents need no reset: every window row 0 overwrites its entry.
  always_ff @(posedge clk) begin
    if (win) rbuf_q[oc_q] <= wbuf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_last_q  <= last_col && last_row;
      out_data_q  <= fin_data;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = state_q != StIdle;
  assign done_o      = state_q == StFin;

endmodule
